// File: rtl/cell_stim_gen.sv
// Stimulus sequencer and response checker for one NIN-input NAND-like cell.
// Drives a programmed vector stream and counts output transitions and mismatches.
module cell_stim_gen #(
  parameter int          NIN       = 3,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] nvec,
  output logic [NIN-1:0]   in_vec,
  output logic             valid,
  output logic             busy,
  output logic             done,
  input  logic             qn_in,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] mism_cnt,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a level request taken only on an edge where the FSM
  // sits in IDLE; busy marks a run in progress and done pulses once at its end.

  localparam int          PW   = (NIN > 1) ? $clog2(NIN) : 1;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] nvec_q;
  logic [CNT_W-1:0] idx;
  logic [15:0]      lfsr;
  logic [PW-1:0]    sw_pos;
  logic             hist;
  logic             qn_prev;

  logic [CNT_W-1:0] idx_nxt;
  logic [CNT_W-1:0] gray_nxt;
  logic [CNT_W:0]   idx_nxt_w;
  logic [15:0]      lfsr_nxt;
  logic [NIN-1:0]   vec_nxt;
  logic             more;
  logic             exp_qn;

  assign state_dbg = state;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [NIN-1:0] first_vec(input logic [1:0] m);
    case (m)
      2'd2:    return SEED[NIN-1:0];
      2'd3:    return {NIN{1'b1}};
      default: return {NIN{1'b0}};
    endcase
  endfunction

  always_comb begin
    idx_nxt   = idx + 1'b1;
    idx_nxt_w = {1'b0, idx} + {{CNT_W{1'b0}}, 1'b1};
    more      = idx_nxt_w < {1'b0, nvec_q};
    gray_nxt  = idx_nxt ^ (idx_nxt >> 1);
    lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    exp_qn    = ~&in_vec;
    vec_nxt   = {NIN{1'b1}};
    case (mode_q)
      2'd0: vec_nxt = idx_nxt[NIN-1:0];
      2'd1: vec_nxt = gray_nxt[NIN-1:0];
      2'd2: vec_nxt = lfsr_nxt[NIN-1:0];
      default: begin
        // Odd indices clear one bit; sw_pos walks the bit position mod NIN.
        if (idx_nxt[0]) vec_nxt[sw_pos] = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      in_vec   <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rise_cnt <= '0;
      fall_cnt <= '0;
      mism_cnt <= '0;
      mode_q   <= '0;
      nvec_q   <= '0;
      idx      <= '0;
      lfsr     <= '0;
      sw_pos   <= '0;
      hist     <= 1'b0;
      qn_prev  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
            mism_cnt <= '0;
            mode_q   <= mode;
            nvec_q   <= nvec;
            idx      <= '0;
            lfsr     <= SEED;
            sw_pos   <= '0;
            hist     <= 1'b0;
            qn_prev  <= 1'b0;
            if (nvec != '0) begin
              in_vec <= first_vec(mode);
              valid  <= 1'b1;
              busy   <= 1'b1;
              state  <= S_RUN;
            end else begin
              done  <= 1'b1;
              state <= S_FIN;
            end
          end
        end
        S_RUN: begin
          if (qn_in != exp_qn) mism_cnt <= sat_inc(mism_cnt);
          if (hist) begin
            if (!qn_prev && qn_in) rise_cnt <= sat_inc(rise_cnt);
            if (qn_prev && !qn_in) fall_cnt <= sat_inc(fall_cnt);
          end
          qn_prev <= qn_in;
          hist    <= 1'b1;
          if (more) begin
            in_vec <= vec_nxt;
            idx    <= idx_nxt;
            lfsr   <= lfsr_nxt;
            if (idx_nxt[0])
              sw_pos <= (sw_pos == PW'(NIN - 1)) ? '0 : sw_pos + 1'b1;
          end else begin
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FIN;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_stim_gen.sv
// Randomized bench for cell_stim_gen: a behavioural vector/response model
// predicts every applied vector and the three result counters.
module tb_cell_stim_gen;

  localparam int NIN   = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] nvec;
  logic [NIN-1:0]   in_vec;
  logic             valid, busy, done;
  logic             qn_in;
  logic [CNT_W-1:0] rise_cnt, fall_cnt, mism_cnt;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  cell_stim_gen #(.NIN(NIN), .CNT_W(CNT_W), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .nvec(nvec),
    .in_vec(in_vec), .valid(valid), .busy(busy), .done(done), .qn_in(qn_in),
    .rise_cnt(rise_cnt), .fall_cnt(fall_cnt), .mism_cnt(mism_cnt),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: vector k of a run, straight from the arithmetic definition.
  function automatic int ref_vec(input int m, input int k);
    int s;
    case (m)
      0: return k % (1 << NIN);
      1: return (k ^ (k >> 1)) % (1 << NIN);
      2: begin
        s = 'hACE1;
        for (int j = 0; j < k; j++) s = (s >> 1) ^ ((s & 1) ? 'hB400 : 0);
        return s % (1 << NIN);
      end
      default: return (k % 2 == 0) ? (1 << NIN) - 1
                                   : ((1 << NIN) - 1) & ~(1 << ((k / 2) % NIN));
    endcase
  endfunction

  function automatic logic nand_of(input int v);
    return (v == (1 << NIN) - 1) ? 1'b0 : 1'b1;
  endfunction

  // qn_kind: 0 ideal cell, 1 output stuck at 1, 2 ideal with random flips.
  task automatic run_seq(input int m, input int nv, input int qn_kind, input bit poke_start);
    logic [NIN-1:0] exp_q[$];
    logic           qn_q[$];
    int rise = 0, fall = 0, mism = 0, v;
    logic q;
    for (int k = 0; k < nv; k++) exp_q.push_back(NIN'(ref_vec(m, k)));
    @(negedge clk);
    start = 1'b1; mode = 2'(m); nvec = CNT_W'(nv);
    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke_start && i == 2) begin
        start = 1'b1; mode = 2'($urandom_range(0, 3)); nvec = CNT_W'($urandom_range(1, 5));
      end
      v = exp_q.pop_front();
      check($sformatf("vec m%0d k%0d", m, i), 32'(in_vec), 32'(v));
      check("valid_run", 32'(valid), 32'd1);
      check("busy_run", 32'(busy), 32'd1);
      check("done_run", 32'(done), 32'd0);
      case (qn_kind)
        1: q = 1'b1;
        2: q = nand_of(v) ^ ($urandom_range(0, 3) == 0);
        default: q = nand_of(v);
      endcase
      qn_in = q;
      if (q != nand_of(v)) mism++;
      if (qn_q.size() > 0) begin
        if (!qn_q[$] && q) rise++;
        if (qn_q[$] && !q) fall++;
      end
      qn_q.push_back(q);
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("valid_end", 32'(valid), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    check($sformatf("rise m%0d n%0d", m, nv), 32'(rise_cnt), 32'(rise));
    check($sformatf("fall m%0d n%0d", m, nv), 32'(fall_cnt), 32'(fall));
    check($sformatf("mism m%0d n%0d", m, nv), 32'(mism_cnt), 32'(mism));
    if (nv > 0) check("hold_vec", 32'(in_vec), 32'(ref_vec(m, nv - 1)));
    @(negedge clk);
    check("done_once", 32'(done), 32'd0);
    check("rise_stable", 32'(rise_cnt), 32'(rise));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = '0; nvec = '0; qn_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vec", 32'(in_vec), 32'd0);
    check("rst_flags", {29'd0, valid, busy, done}, 32'd0);
    check("rst_cnts", 32'(rise_cnt | fall_cnt | mism_cnt), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    run_seq(0, 8, 0, 1'b0);
    check("plan0_fall", 32'(fall_cnt), 32'd1);
    check("plan0_rise", 32'(rise_cnt), 32'd0);
    run_seq(1, 8, 0, 1'b0);
    check("plan1_rise", 32'(rise_cnt), 32'd1);
    check("plan1_fall", 32'(fall_cnt), 32'd1);
    run_seq(3, 6, 0, 1'b0);
    check("plan3_rise", 32'(rise_cnt), 32'd3);
    check("plan3_fall", 32'(fall_cnt), 32'd2);
    run_seq(0, 10, 1, 1'b0);
    check("plan_tied_mism", 32'(mism_cnt), 32'd1);
    run_seq(2, 3, 0, 1'b0);
    run_seq(0, 0, 0, 1'b0);
    run_seq(1, 7, 2, 1'b1);

    // Reset in the middle of a run: no DONE, everything back to zero.
    @(negedge clk);
    start = 1'b1; mode = 2'd0; nvec = CNT_W'(8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      qn_in = nand_of(i);
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_vec", 32'(in_vec), 32'd0);
    check("mid_rst_flags", {29'd0, valid, busy, done}, 32'd0);
    check("mid_rst_cnts", 32'(rise_cnt | fall_cnt | mism_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_nodone", 32'(done), 32'd0);
    run_seq(0, 8, 0, 1'b0);
    check("rerun_fall", 32'(fall_cnt), 32'd1);

    for (int r = 0; r < 25; r++)
      run_seq($urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
